led_mode_ctrl: RTL

Mode sequencer and scheduler for the board LED blink datapath. It owns one shared prescaler counter and steps the LED through OFF, ON, SLOW-blink and FAST-blink modes on a user pulse. It also schedules one-shot "burst" flash requests that temporarily take over the LED and then hand it back to the selected mode. It sits between the debounced key logic and the LED pin.

---
 rtl/led_mode_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/led_mode_ctrl.sv
// LED mode sequencer (OFF/ON/SLOW/FAST) on one shared prescaler, with one-shot
// burst flashing compiled in only when LED_MODE_CTRL_BURST_EN is defined.
module led_mode_ctrl #(
    parameter logic [24:0] CNT_MAX  = 25'd24_999_999,
    parameter logic [3:0]  SLOW_MUL = 4'd4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       mode_step,
    input  logic       burst_req,
    input  logic [3:0] burst_len,
    output logic       burst_busy,
    output logic       burst_done,
    output logic [1:0] mode,
    output logic       led_out
);
    localparam logic [1:0] MODE_OFF  = 2'd0;
    localparam logic [1:0] MODE_ON   = 2'd1;
    localparam logic [1:0] MODE_SLOW = 2'd2;
    localparam logic [1:0] MODE_FAST = 2'd3;
    localparam logic [3:0] DIV_LAST  = SLOW_MUL - 4'd1;

    logic [24:0] cnt_q, cnt_d;
    logic [3:0]  div_q, div_d;
    logic        phase_q, phase_d;
    logic [1:0]  mode_q, mode_d;
    logic        led_q, led_d;
    logic        tick_s;

    assign tick_s = (cnt_q == CNT_MAX);

    function automatic logic mode_led(input logic [1:0] m, input logic ph);
        case (m)
            MODE_OFF: mode_led = 1'b0;
            MODE_ON:  mode_led = 1'b1;
            default:  mode_led = ph;
        endcase
    endfunction

`ifdef LED_MODE_CTRL_BURST_EN
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] len_q, len_d;
    logic [3:0] flash_q, flash_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
`else
    logic unused_burst_s;
    assign unused_burst_s = burst_req ^ (^burst_len);
`endif

    // Next-state: mode stepping, prescaler, blink phase and burst takeover
    always_comb begin
        mode_d = mode_step ? (mode_q + 2'd1) : mode_q;
        if (mode_step) begin
            cnt_d   = 25'd0;
            div_d   = 4'd0;
            phase_d = 1'b1;
        end else if (tick_s) begin
            cnt_d = 25'd0;
            div_d = (div_q == DIV_LAST) ? 4'd0 : (div_q + 4'd1);
            if ((mode_q == MODE_FAST) || ((mode_q == MODE_SLOW) && (div_q == DIV_LAST))) begin
                phase_d = ~phase_q;
            end else begin
                phase_d = phase_q;
            end
        end else begin
            cnt_d   = cnt_q + 25'd1;
            div_d   = div_q;
            phase_d = phase_q;
        end
        led_d = mode_led(mode_d, phase_d);
`ifdef LED_MODE_CTRL_BURST_EN
        state_d = state_q;
        len_d   = len_q;
        flash_d = flash_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (burst_req && (burst_len != 4'd0)) begin
                    state_d = BURST;
                    len_d   = burst_len;
                    flash_d = 4'd0;
                    cnt_d   = 25'd0;
                    phase_d = 1'b1;
                    busy_d  = 1'b1;
                    led_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            BURST: begin
                // The burst owns the prescaler; mode_step only moves the mode register.
                div_d   = div_q;
                cnt_d   = tick_s ? 25'd0 : (cnt_q + 25'd1);
                phase_d = tick_s ? ~phase_q : phase_q;
                led_d   = phase_d;
                if (tick_s && !phase_q) begin
                    if ((flash_q + 4'd1) == len_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = 25'd0;
                        div_d   = 4'd0;
                        phase_d = 1'b1;
                        led_d   = mode_led(mode_d, 1'b1);
                    end else begin
                        flash_d = flash_q + 4'd1;
                    end
                end else begin
                    flash_d = flash_q;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
`endif
    end

    // Mode, prescaler and LED registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q   <= 25'd0;
            div_q   <= 4'd0;
            phase_q <= 1'b1;
            mode_q  <= MODE_OFF;
            led_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
        end
    end

`ifdef LED_MODE_CTRL_BURST_EN
    // Burst FSM registers
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            len_q   <= 4'd0;
            flash_q <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            flash_q <= flash_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign burst_busy = busy_q;
    assign burst_done = done_q;
`else
    assign burst_busy = 1'b0;
    assign burst_done = 1'b0;
`endif

    assign mode    = mode_q;
    assign led_out = led_q;

endmodule
